// File: rtl/encoder_speed_meter_if.sv
// -----------------------------------------------------------------------------
// encoder_speed_meter_if
//   Bundles the control inputs, raw sensor inputs and latched measurement
//   outputs of encoder_speed_meter. Clock and reset stay plain module ports.
//
//   Signals
//     enable  master->slave  1 = measuring, 0 = freeze timing / clear accumulators
//     mode    master->slave  0 = unsigned SA rising-edge count, 1 = signed quadrature
//     sa      master->slave  raw SA per channel (asynchronous)
//     sb      master->slave  raw SB per channel (asynchronous)
//     count   slave->master  latched window counts, channel i at [i*CNT_W +: CNT_W]
//     dir     slave->master  1 = latched count negative (signed mode only)
//     ovf     slave->master  1 = channel saturated during the latched window
//     valid   slave->master  one-clock pulse when count/dir/ovf update
// -----------------------------------------------------------------------------
interface encoder_speed_meter_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    logic                    enable;
    logic                    mode;
    logic [NUM_CH-1:0]       sa;
    logic [NUM_CH-1:0]       sb;
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH-1:0]       dir;
    logic [NUM_CH-1:0]       ovf;
    logic                    valid;

    modport master (
        output enable, mode, sa, sb,
        input  count, dir, ovf, valid
    );

    modport slave (
        input  enable, mode, sa, sb,
        output count, dir, ovf, valid
    );
endinterface

// File: rtl/encoder_speed_meter.sv
// -----------------------------------------------------------------------------
// encoder_speed_meter
//   Multi-channel Hall/encoder speed meter. Each channel synchronises and
//   glitch-filters its SA/SB inputs on a prescaled sample tick, counts filtered
//   SA rising edges over a fixed gate window, and publishes a saturating count
//   per window together with a one-clock valid strobe.
//
//   Ports
//     clock     in   system clock
//     reset     in   synchronous, active-low reset
//     meter_if  slave modport of encoder_speed_meter_if
//                 enable, mode, sa, sb   : inputs
//                 count, dir, ovf, valid : registered outputs
// -----------------------------------------------------------------------------
module encoder_speed_meter #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 16,
    parameter int PRESCALE   = 100,
    parameter int GATE_TICKS = 170455,
    parameter int FILT_LEN   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    encoder_speed_meter_if.slave  meter_if
);

    localparam int PRESC_W = $clog2(PRESCALE);
    localparam int GATE_W  = $clog2(GATE_TICKS);
    localparam int RUN_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(PRESCALE - 1);
    localparam logic [GATE_W-1:0]  GATE_LAST    = GATE_W'(GATE_TICKS - 1);
    // The run counter only needs to reach FILT_LEN-1: the next differing
    // sample is the one that completes the run.
    localparam logic [RUN_W-1:0]   RUN_LAST     = RUN_W'(FILT_LEN - 1);

    localparam logic [CNT_W-1:0] UMAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SMAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] SMIN = {1'b1, {(CNT_W-1){1'b0}}};

    // One saturating accumulator step. Result is {sat_hit, next_acc}.
    // In unsigned mode the limit is all-ones; in signed mode it is the
    // two's-complement extreme in the direction of travel.
    function automatic logic [CNT_W:0] acc_step(
        input logic [CNT_W-1:0] acc,
        input logic             up,
        input logic             sgn
    );
        logic [CNT_W-1:0] lim;
        lim = !sgn ? UMAX : (up ? SMAX : SMIN);
        if (acc == lim) begin
            acc_step = {1'b1, acc};
        end else begin
            acc_step = {1'b0, (up ? acc + 1'b1 : acc - 1'b1)};
        end
    endfunction

    // Timing state
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic               mode_q, mode_d;
    logic               tick;
    logic               win_end;

    // Input synchronisers
    logic [NUM_CH-1:0] sa_meta_q, sa_sync_q;
    logic [NUM_CH-1:0] sb_meta_q, sb_sync_q;

    // Glitch filters
    logic [NUM_CH-1:0] sa_filt_q, sa_filt_d;
    logic [NUM_CH-1:0] sb_filt_q, sb_filt_d;
    logic [RUN_W-1:0]  sa_run_q [NUM_CH];
    logic [RUN_W-1:0]  sa_run_d [NUM_CH];
    logic [RUN_W-1:0]  sb_run_q [NUM_CH];
    logic [RUN_W-1:0]  sb_run_d [NUM_CH];
    logic [NUM_CH-1:0] rise;

    // Accumulators
    logic [CNT_W-1:0]  acc_q    [NUM_CH];
    logic [CNT_W-1:0]  acc_d    [NUM_CH];
    logic [CNT_W-1:0]  acc_nx   [NUM_CH];
    logic [CNT_W:0]    step_res [NUM_CH];
    logic [NUM_CH-1:0] sat_q, sat_d, sat_nx;

    // Published results
    logic [NUM_CH*CNT_W-1:0] count_q, count_d;
    logic [NUM_CH-1:0]       dir_q, dir_d;
    logic [NUM_CH-1:0]       ovf_q, ovf_d;
    logic                    valid_q, valid_d;

    assign tick    = meter_if.enable && (presc_q == '0);
    assign win_end = tick && (gate_q == GATE_LAST);

    always_comb begin
        presc_d = presc_q;
        if (meter_if.enable) begin
            presc_d = (presc_q == '0) ? PRESC_RELOAD : presc_q - 1'b1;
        end

        gate_d = gate_q;
        if (tick) begin
            gate_d = win_end ? '0 : gate_q + 1'b1;
        end

        mode_d  = win_end ? meter_if.mode : mode_q;
        valid_d = win_end;

        count_d = count_q;
        dir_d   = dir_q;
        ovf_d   = ovf_q;

        for (int i = 0; i < NUM_CH; i++) begin
            // Filters advance only on ticks; a level is accepted after
            // FILT_LEN consecutive differing samples.
            sa_filt_d[i] = sa_filt_q[i];
            sa_run_d[i]  = sa_run_q[i];
            sb_filt_d[i] = sb_filt_q[i];
            sb_run_d[i]  = sb_run_q[i];
            if (tick) begin
                if (sa_sync_q[i] != sa_filt_q[i]) begin
                    if (sa_run_q[i] == RUN_LAST) begin
                        sa_filt_d[i] = sa_sync_q[i];
                        sa_run_d[i]  = '0;
                    end else begin
                        sa_run_d[i]  = sa_run_q[i] + 1'b1;
                    end
                end else begin
                    sa_run_d[i] = '0;
                end

                if (sb_sync_q[i] != sb_filt_q[i]) begin
                    if (sb_run_q[i] == RUN_LAST) begin
                        sb_filt_d[i] = sb_sync_q[i];
                        sb_run_d[i]  = '0;
                    end else begin
                        sb_run_d[i]  = sb_run_q[i] + 1'b1;
                    end
                end else begin
                    sb_run_d[i] = '0;
                end
            end

            rise[i] = tick && !sa_filt_q[i] && sa_filt_d[i];

            // Direction uses the SB level as filtered on this same tick.
            step_res[i] = acc_step(acc_q[i], !(mode_q && sb_filt_d[i]), mode_q);
            acc_nx[i]   = acc_q[i];
            sat_nx[i]   = sat_q[i];
            if (rise[i]) begin
                acc_nx[i] = step_res[i][CNT_W-1:0];
                sat_nx[i] = sat_q[i] | step_res[i][CNT_W];
            end

            // The window-end latch takes the post-edge value so an edge on
            // the final tick belongs to the closing window.
            if (win_end) begin
                count_d[i*CNT_W +: CNT_W] = acc_nx[i];
                ovf_d[i]                  = sat_nx[i];
                dir_d[i]                  = mode_q & acc_nx[i][CNT_W-1];
            end

            if (!meter_if.enable || win_end) begin
                acc_d[i] = '0;
                sat_d[i] = 1'b0;
            end else begin
                acc_d[i] = acc_nx[i];
                sat_d[i] = sat_nx[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            presc_q   <= PRESC_RELOAD;
            gate_q    <= '0;
            mode_q    <= meter_if.mode;
            sa_meta_q <= '0;
            sa_sync_q <= '0;
            sb_meta_q <= '0;
            sb_sync_q <= '0;
            sa_filt_q <= '0;
            sb_filt_q <= '0;
            sat_q     <= '0;
            count_q   <= '0;
            dir_q     <= '0;
            ovf_q     <= '0;
            valid_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sa_run_q[i] <= '0;
                sb_run_q[i] <= '0;
                acc_q[i]    <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            gate_q    <= gate_d;
            mode_q    <= mode_d;
            sa_meta_q <= meter_if.sa;
            sa_sync_q <= sa_meta_q;
            sb_meta_q <= meter_if.sb;
            sb_sync_q <= sb_meta_q;
            sa_filt_q <= sa_filt_d;
            sb_filt_q <= sb_filt_d;
            sat_q     <= sat_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            for (int i = 0; i < NUM_CH; i++) begin
                sa_run_q[i] <= sa_run_d[i];
                sb_run_q[i] <= sb_run_d[i];
                acc_q[i]    <= acc_d[i];
            end
        end
    end

    assign meter_if.count = count_q;
    assign meter_if.dir   = dir_q;
    assign meter_if.ovf   = ovf_q;
    assign meter_if.valid = valid_q;

endmodule
